// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types for the time-multiplexed "1101" detector.
// Holds the 2-bit detector context type, its S0..S3 encodings and the pattern.
package seq_det_pkg;

    typedef logic [1:0] ctx_t;

    // S0: no match, S1: "1", S2: "11", S3: "110"
    localparam ctx_t S0 = 2'b00;
    localparam ctx_t S1 = 2'b01;
    localparam ctx_t S2 = 2'b10;
    localparam ctx_t S3 = 2'b11;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_step.sv
// seq_det_step: one combinational step of the overlapping "1101" detector.
// Ports: ctx (current context), din (bit), ctx_next (next context), hit (pattern done).
module seq_det_step
    import seq_det_pkg::*;
(
    input  ctx_t ctx,
    input  logic din,
    output ctx_t ctx_next,
    output logic hit
);

    always_comb begin
        ctx_next = S0;
        hit      = 1'b0;
        case (ctx)
            S0: ctx_next = din ? S1 : S0;
            S1: ctx_next = din ? S2 : S0;
            S2: ctx_next = din ? S2 : S3;
            S3: begin
                // "110" + '1' completes the pattern; its trailing '1' seeds S1
                ctx_next = din ? S1 : S0;
                hit      = din;
            end
            default: ctx_next = S0;
        endcase
    end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin shares one "1101" detector step among NCH bit channels.
// Ports: clk, reset (async, active-high), bit_valid/bit_din/bit_ready (per-channel
// handshake), clear_cnt, match_valid/match_ch (registered hit pulse), match_count
// (flattened saturating counters). Option SEQ_SCHED_FLUSH_EN adds ch_flush.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           bit_valid,
    input  logic [NCH-1:0]           bit_din,
    output logic [NCH-1:0]           bit_ready,
    input  logic                     clear_cnt,
`ifdef SEQ_SCHED_FLUSH_EN
    input  logic [NCH-1:0]           ch_flush,
`endif
    output logic                     match_valid,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic [NCH*CNT_W-1:0]     match_count
);

    localparam int PW = $clog2(NCH);

    ctx_t             ctx [NCH];
    logic [CNT_W-1:0] cnt [NCH];
    logic [PW-1:0]    rr_ptr;

    logic [PW-1:0]    gnt;
    logic             take;
    ctx_t             step_next;
    logic             step_hit;
    logic             hit;
    logic [NCH-1:0]   flush;

`ifdef SEQ_SCHED_FLUSH_EN
    assign flush = ch_flush;
`else
    assign flush = '0;
`endif

    // First valid channel at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        take = 1'b0;
        gnt  = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!take && bit_valid[idx]) begin
                take = 1'b1;
                gnt  = PW'(idx);
            end
        end
        bit_ready = take ? (NCH'(1) << gnt) : '0;
    end

    seq_det_step u_step (
        .ctx      (ctx[gnt]),
        .din      (bit_din[gnt]),
        .ctx_next (step_next),
        .hit      (step_hit)
    );

    // A flushed channel still completes its handshake but cannot hit.
    assign hit = take & step_hit & ~flush[gnt];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NCH; i++) ctx[i] <= S0;
        end else begin
            if (take)
                rr_ptr <= (gnt == PW'(NCH - 1)) ? '0 : gnt + PW'(1);
            for (int i = 0; i < NCH; i++) begin
                if (flush[i])
                    ctx[i] <= S0;
                else if (take && gnt == PW'(i))
                    ctx[i] <= step_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clear_cnt)
                    cnt[i] <= '0;
                else if (hit && gnt == PW'(i) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= hit;
            if (hit) match_ch <= gnt;
        end
    end

    always_comb begin
        match_count = '0;
        for (int i = 0; i < NCH; i++)
            match_count[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed and random stimulus for seq_det_sched (NCH=4, CNT_W=2),
// checked each cycle against a history-based behavioural model.
module tb_seq_det_sched;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NCH-1:0]         bit_valid = '0;
    logic [NCH-1:0]         bit_din = '0;
    logic [NCH-1:0]         bit_ready;
    logic                   clear_cnt = 1'b0;
`ifdef SEQ_SCHED_FLUSH_EN
    logic [NCH-1:0]         ch_flush = '0;
`endif
    logic                   match_valid;
    logic [1:0]             match_ch;
    logic [NCH*CNT_W-1:0]   match_count;

    int checks = 0;
    int errors = 0;

    seq_det_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_din     (bit_din),
        .bit_ready   (bit_ready),
        .clear_cnt   (clear_cnt),
`ifdef SEQ_SCHED_FLUSH_EN
        .ch_flush    (ch_flush),
`endif
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel keeps its last 4 accepted bits since reset/flush;
    // a hit is simply "those bits read 1101".
    function automatic int grant_of(input logic [NCH-1:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (p + k) % NCH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    int         m_ptr, m_ptr_n, m_g, m_ch, m_ch_n;
    logic [3:0] m_hist [NCH];
    logic [3:0] m_hist_n [NCH];
    int         m_cnt [NCH];
    int         m_cnt_n [NCH];
    logic       m_hit, m_mv;
    logic [NCH-1:0] m_fl;

    always_comb begin
        m_g      = grant_of(bit_valid, m_ptr);
        m_hist_n = m_hist;
        m_cnt_n  = m_cnt;
        m_ptr_n  = m_ptr;
        m_hit    = 1'b0;
`ifdef SEQ_SCHED_FLUSH_EN
        m_fl = ch_flush;
`else
        m_fl = '0;
`endif
        if (m_g >= 0) begin
            m_hist_n[m_g] = {m_hist[m_g][2:0], bit_din[m_g]};
            m_hit   = (m_hist_n[m_g] == 4'b1101);
            m_ptr_n = (m_g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (m_fl[i]) begin
                m_hist_n[i] = 4'b0000;
                if (i == m_g) m_hit = 1'b0;
            end
        end
        if (clear_cnt) begin
            for (int i = 0; i < NCH; i++) m_cnt_n[i] = 0;
        end else if (m_hit && m_cnt[m_g] < CMAX) begin
            m_cnt_n[m_g] = m_cnt[m_g] + 1;
        end
        m_ch_n = m_hit ? m_g : m_ch;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr  <= 0;
            m_hist <= '{default: 4'b0000};
            m_cnt  <= '{default: 0};
            m_mv   <= 1'b0;
            m_ch   <= 0;
        end else begin
            m_ptr  <= m_ptr_n;
            m_hist <= m_hist_n;
            m_cnt  <= m_cnt_n;
            m_mv   <= m_hit;
            m_ch   <= m_ch_n;
        end
    end

    // Compare process: mid low phase, inputs and registered outputs are settled.
    always @(negedge clk) begin
        logic [NCH-1:0] exp_rdy;
        int exp_cnt;
        #1;
        exp_rdy = (m_g >= 0) ? (NCH'(1) << m_g) : '0;
        exp_cnt = 0;
        for (int i = 0; i < NCH; i++) exp_cnt = exp_cnt | (m_cnt[i] << (i * CNT_W));
        chk("model_bit_ready", int'(bit_ready), int'(exp_rdy));
        chk("model_match_valid", int'(match_valid), int'(m_mv));
        chk("model_match_ch", int'(match_ch), m_ch);
        chk("model_match_count", int'(match_count), exp_cnt);
    end

    task automatic send(input logic [NCH-1:0] v, input logic [NCH-1:0] d,
                        input logic clr, input logic [NCH-1:0] fl,
                        output logic [NCH-1:0] rdy);
        @(negedge clk);
        bit_valid = v;
        bit_din   = d;
        clear_cnt = clr;
`ifdef SEQ_SCHED_FLUSH_EN
        ch_flush  = fl;
`else
        if (fl != '0) $display("note: flush ignored in this build");
`endif
        #1 rdy = bit_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        logic [NCH-1:0] r;
        send('0, '0, 1'b0, '0, r);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    function automatic int cnt_of(input int ch);
        return int'((match_count >> (ch * CNT_W)) & CMAX);
    endfunction

    initial begin
        logic [NCH-1:0] r;
        logic [6:0]  s7;
        logic [3:0]  s4;
        logic [15:0] s16;
        logic        b;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_match_valid", int'(match_valid), 0);
        chk("reset_match_ch", int'(match_ch), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_ready", int'(bit_ready), 0);
        #2 reset = 1'b0;

        // Single channel, overlapping 1101101
        s7 = 7'b1101101;
        for (int i = 0; i < 7; i++) begin
            send(4'b0001, {3'b000, s7[6-i]}, 1'b0, '0, r);
            chk("single_ready", int'(r), 1);
            chk("single_mv", int'(match_valid), (i == 3 || i == 6) ? 1 : 0);
        end
        chk("single_ch", int'(match_ch), 0);
        chk("single_cnt0", cnt_of(0), 2);
        idle();

        // Interleave ch0/ch1
        pulse_reset();
        s4 = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            b = s4[3 - k/2];
            send(4'b0011, {2'b00, b, b}, 1'b0, '0, r);
            chk("inter_ready", int'(r), (k % 2 == 0) ? 1 : 2);
            chk("inter_mv", int'(match_valid), (k >= 6) ? 1 : 0);
            if (k >= 6) chk("inter_ch", int'(match_ch), k - 6);
        end
        chk("inter_cnt0", cnt_of(0), 1);
        chk("inter_cnt1", cnt_of(1), 1);
        idle();

        // Fairness over four channels
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            send(4'b1111, 4'($urandom_range(15)), 1'b0, '0, r);
            chk("fair_ready", int'(r), 1 << (k % 4));
        end
        idle();

        // Saturation then clear coinciding with a hit
        pulse_reset();
        s16 = 16'b1101101101101101;
        for (int i = 0; i < 16; i++)
            send(4'b0100, {1'b0, s16[15-i], 2'b00}, 1'b0, '0, r);
        chk("sat_cnt2", cnt_of(2), 3);
        send(4'b0100, 4'b0100, 1'b0, '0, r);
        send(4'b0100, 4'b0000, 1'b0, '0, r);
        send(4'b0100, 4'b0100, 1'b1, '0, r);
        chk("clr_mv", int'(match_valid), 1);
        chk("clr_ch", int'(match_ch), 2);
        chk("clr_cnt2", cnt_of(2), 0);
        idle();

        // Reset mid-pattern
        pulse_reset();
        send(4'b0001, 4'b0001, 1'b0, '0, r);
        send(4'b0001, 4'b0001, 1'b0, '0, r);
        send(4'b0001, 4'b0000, 1'b0, '0, r);
        idle();
        pulse_reset();
        send(4'b0001, 4'b0001, 1'b0, '0, r);
        chk("rstmid_nohit", int'(match_valid), 0);
        for (int i = 0; i < 4; i++) begin
            send(4'b0001, {3'b000, s4[3-i]}, 1'b0, '0, r);
            chk("rstmid_mv", int'(match_valid), (i == 3) ? 1 : 0);
        end
        chk("rstmid_cnt0", cnt_of(0), 1);
        idle();

`ifdef SEQ_SCHED_FLUSH_EN
        pulse_reset();
        send(4'b0010, 4'b0010, 1'b0, '0, r);
        send(4'b0010, 4'b0010, 1'b0, '0, r);
        send(4'b0010, 4'b0000, 1'b0, '0, r);
        send(4'b0010, 4'b0010, 1'b0, 4'b0010, r);
        chk("flush_ready", int'(r), 2);
        chk("flush_nohit", int'(match_valid), 0);
        for (int i = 0; i < 4; i++) begin
            send(4'b0010, {2'b00, s4[3-i], 1'b0}, 1'b0, '0, r);
            chk("flush_mv", int'(match_valid), (i == 3) ? 1 : 0);
        end
        chk("flush_cnt1", cnt_of(1), 1);
        idle();
`endif

        // Random traffic, checked by the compare process each cycle
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] fl;
            fl = ($urandom_range(7) == 0) ? NCH'($urandom_range(15)) : '0;
`ifndef SEQ_SCHED_FLUSH_EN
            fl = '0;
`endif
            // bias din towards '1' so patterns complete often
            send(NCH'($urandom_range(15)),
                 NCH'($urandom_range(15)) | NCH'($urandom_range(15)),
                 ($urandom_range(15) == 0), fl, r);
            if ($urandom_range(199) == 0) pulse_reset();
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Time-multiplexed controller that shares one "1101" overlapping-pattern detector step between NCH serial bit channels. Each channel offers one bit per transfer through a valid/ready handshake. A round-robin arbiter grants one channel per cycle. The controller saves and restores each channel's 2-bit detector context, issues a registered match pulse tagged with the channel, and keeps a saturating per-channel match count. It sits between the per-channel serial front ends and the status/interrupt logic.

## Interface
- NCH, default 4: number of channels, 2..8.
- CNT_W, default 8: width of each per-channel match counter.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- bit_valid  in  NCH  channel i offers a bit.
- bit_din  in  NCH  bit value for channel i.
- bit_ready  out  NCH  one-hot or zero; a transfer happens on channel i when bit_valid[i] and bit_ready[i] are both high.
- clear_cnt  in  1  synchronous clear of all match counters.
- match_valid  out  1  one-cycle pulse: a pattern completed.
- match_ch  out  $clog2(NCH)  channel of the current match_valid.
- match_count  out  NCH*CNT_W  flattened counters; channel i occupies [i*CNT_W +: CNT_W].

## Operation
- Per-channel context ctx[i] is 2 bits:
  - S0: no match.
  - S1: suffix "1".
  - S2: suffix "11".
  - S3: suffix "110".
- Detector step from (ctx, din) to (next ctx, hit):
  - S0: 1 -> S1; 0 -> S0.
  - S1: 1 -> S2; 0 -> S0.
  - S2: 1 -> S2; 0 -> S3.
  - S3: 1 -> S1 with hit = 1; 0 -> S0.
  - hit = 0 in every other case.
  - Overlap is supported: "1101101" produces 2 hits.
- Arbitration:
  - Round-robin pointer rr_ptr.
  - Grant goes to the first i with bit_valid[i] high, searching from rr_ptr upward and wrapping modulo NCH.
  - bit_ready is that grant, combinationally derived from bit_valid and rr_ptr.
  - When no channel is valid: bit_ready = 0, and rr_ptr and all contexts hold.
  - After a grant to channel g: rr_ptr <= (g+1) mod NCH.
- On a transfer on channel g:
  - ctx[g] updates to the step result.
  - Every other channel's ctx holds.
- Match counter for channel g on a hit:
  - Increments, saturating at 2^CNT_W-1.
  - The counter does not wrap.
- clear_cnt:
  - Sets all counters to 0 at the next edge.
  - If clear_cnt coincides with a hit, clear wins (counter = 0), but match_valid still pulses.
- Contexts are never altered by clear_cnt.
- Reset values:
  - All ctx = S0.
  - rr_ptr = 0.
  - match_valid = 0.
  - match_ch = 0.
  - All counters = 0.
- Reset asserted mid-stream discards all contexts immediately. After reset, bit_ready reflects the arbitration with rr_ptr = 0.

## Timing
- Throughput: one bit transfer per cycle in aggregate. With k channels valid continuously, each gets one transfer every k cycles.
- Latency: match_valid and match_ch are registered and assert in the cycle after the edge that accepts the completing '1'. They stay high for exactly one cycle per hit.
- match_count reflects a hit in the same cycle match_valid asserts.
- bit_ready has no dependence on bit_din.
- A channel may drop bit_valid while not granted without any effect.
- match_ch holds its last value while match_valid = 0.

## Configuration
- SEQ_SCHED_FLUSH_EN defined: adds input ch_flush (NCH bits).
  - ch_flush[i] forces ctx[i] to S0 at the next edge.
  - If flush coincides with a transfer on the same channel, the bit is accepted (handshake completes) but ctx goes to S0 and no hit is produced.
  - Flush does not affect counters or arbitration.
- SEQ_SCHED_FLUSH_EN undefined: the port is absent and contexts change only on transfers and reset.

## Structure
- Shared package seq_det_pkg holds:
  - the context typedef and the S0..S3 encodings (00, 01, 10, 11);
  - the pattern constant 4'b1101.
- One sub-module, seq_det_step: purely combinational, maps (ctx, din) to (ctx_next, hit).
- seq_det_sched holds the context array, arbiter, counters and output registers.

## Test plan
- Reset, single channel: ch0 streams 1,1,0,1,1,0,1. Expect match_valid pulses after the 4th and 7th accepted bits, match_ch = 0, and count[0] = 2.
- Interleave: ch0 and ch1 both valid continuously, sending 1101 each. Expect grants alternating 0,1,0,1 and hits on both with their contexts independent. ch1's match arrives one cycle after ch0's.
- Fairness: all 4 channels valid for 8 cycles, starting with rr_ptr = 0. Expect the grant order 0,1,2,3,0,1,2,3, with no channel starved.
- Saturation and clear: CNT_W = 2, 5 hits on ch2. Expect count[2] = 3. Then assert clear_cnt together with a hit: expect count 0 and match_valid = 1.
- Reset mid-pattern: ch0 sends 1,1,0, then async reset, then 1. Expect no match. Then 1,1,0,1 gives exactly one match.
- With SEQ_SCHED_FLUSH_EN: ch1 sends 1,1,0, then ch_flush[1] together with a '1' transfer. Expect no hit and ctx[1] = S0. Then 1,1,0,1 gives one hit.
